// File: rtl/ram_bank_sched_pkg.sv
// ram_bank_sched_pkg
//   Shared encodings for the RAM bank scheduler: bank life-cycle states,
//   port-owner FSM codes, default RAM geometry and a ring pointer helper.
package ram_bank_sched_pkg;

   localparam int RAM_AW     = 10;
   localparam int RAM_DW     = 4;
   localparam int NBANKS_DEF = 4;
   localparam int PTR_W      = 3;   // bank index width, fixed by osel_ram
   localparam int MAX_BANKS  = 8;

   // Bank life cycle: EMPTY -> FULL (filled from card) -> DONE (XORed) -> EMPTY (sent)
   typedef enum logic [1:0] {
      BK_EMPTY = 2'd0,
      BK_FULL  = 2'd1,
      BK_DONE  = 2'd2
   } bank_st_e;

   // Port owner FSM
   localparam logic [1:0] OWN_IDLE = 2'd0;
   localparam logic [1:0] OWN_SD   = 2'd1;
   localparam logic [1:0] OWN_XOR  = 2'd2;

   // Ring pointer increment, wrapping at n-1
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input int n);
      return (p == PTR_W'(n - 1)) ? '0 : p + PTR_W'(1);
   endfunction

endpackage

// File: rtl/ram_bank_sched_rr_arb2.sv
// rr_arb2
//   Two-requester round-robin arbiter. When both request, the side that did
//   not win last time is granted. The last-winner register only moves when
//   iupd is high and a grant is issued.
// Ports
//   iclk, irst : clock, async active-high reset (last winner resets to req[1])
//   ireq[1:0]  : requests (bit 0 = SD, bit 1 = XOR)
//   iupd       : arbitration decision is being taken this cycle
//   ognt[1:0]  : one-hot combinational grant
module rr_arb2 (
   input  logic       iclk,
   input  logic       irst,
   input  logic [1:0] ireq,
   input  logic       iupd,
   output logic [1:0] ognt
);

   logic last_q;   // 1 = requester 1 won last

   always_comb begin
      ognt = ireq;
      if (&ireq) ognt = last_q ? 2'b01 : 2'b10;
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst)                   last_q <= 1'b1;
      else if (iupd && (|ognt))   last_q <= ognt[1];
   end

endmodule

// File: rtl/ram_bank_sched.sv
// ram_bank_sched
//   Owns the RAM bank ring shared by the SD D-line driver and the OTP XOR
//   engine. Tracks per-bank state, grants the single RAM port to one side at
//   a time and muxes address / write data / write enable onto the RAM.
// Ports
//   iclk, irst                       : clock, async active-high reset
//   isd_req/dir/done/addr/wdata/we   : SD requester (dir 0 = FILL, 1 = SEND)
//   osd_gnt, osd_bank                : SD grant and granted bank
//   ixor_req/done/addr/wdata/we      : XOR engine requester
//   oxor_gnt, oxor_bank              : XOR grant and granted bank
//   osel_ram, oaddr, owdata, owrite_en : RAM port
//   irdata                           : RAM read data (requesters tap it directly)
//   ofree, oidle                     : registered EMPTY-bank count / all idle
//   oerr                             : registered 1-cycle protocol error pulse
module ram_bank_sched
   import ram_bank_sched_pkg::*;
#(
   parameter int NBANKS = NBANKS_DEF,
   parameter int AW     = RAM_AW,
   parameter int DW     = RAM_DW
) (
   input  logic          iclk,
   input  logic          irst,
   input  logic          isd_req,
   input  logic          isd_dir,
   input  logic          isd_done,
   input  logic [AW-1:0] isd_addr,
   input  logic [DW-1:0] isd_wdata,
   input  logic          isd_we,
   output logic          osd_gnt,
   output logic [2:0]    osd_bank,
   input  logic          ixor_req,
   input  logic          ixor_done,
   input  logic [AW-1:0] ixor_addr,
   input  logic [DW-1:0] ixor_wdata,
   input  logic          ixor_we,
   output logic          oxor_gnt,
   output logic [2:0]    oxor_bank,
   output logic [2:0]    osel_ram,
   output logic [AW-1:0] oaddr,
   output logic [DW-1:0] owdata,
   output logic          owrite_en,
   input  logic [DW-1:0] irdata,
   output logic [3:0]    ofree,
   output logic          oidle,
   output logic          oerr
);

   // Storage is sized for the 3-bit pointer range; entries >= NBANKS never leave EMPTY.
   bank_st_e         bank_q [MAX_BANKS];
   bank_st_e         bank_d [MAX_BANKS];
   logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;
   logic [PTR_W-1:0] proc_ptr_q, proc_ptr_d;
   logic [PTR_W-1:0] send_ptr_q, send_ptr_d;
   logic [1:0]       owner_q, owner_d;
   logic             dir_q, dir_d;
   logic [PTR_W-1:0] gbank_q, gbank_d;
   logic [3:0]       free_q, free_d;
   logic             idle_q, idle_d;
   logic             err_q, err_d;

   logic             sd_elig, xor_elig;
   logic [1:0]       arb_gnt;
   logic             sd_own, xor_own;
   logic             unused_rdata;

   assign unused_rdata = ^irdata;

   // Eligibility depends on the bank the relevant pointer currently names
   assign sd_elig  = isd_req & (isd_dir ? (bank_q[send_ptr_q] == BK_DONE)
                                        : (bank_q[fill_ptr_q] == BK_EMPTY));
   assign xor_elig = ixor_req & (bank_q[proc_ptr_q] == BK_FULL);

   rr_arb2 u_arb (
      .iclk (iclk),
      .irst (irst),
      .ireq ({xor_elig, sd_elig}),
      .iupd (owner_q == OWN_IDLE),
      .ognt (arb_gnt)
   );

   always_comb begin
      bank_d     = bank_q;
      fill_ptr_d = fill_ptr_q;
      proc_ptr_d = proc_ptr_q;
      send_ptr_d = send_ptr_q;
      owner_d    = owner_q;
      dir_d      = dir_q;
      gbank_d    = gbank_q;
      err_d      = 1'b0;
      free_d     = '0;
      idle_d     = 1'b0;

      case (owner_q)
         OWN_IDLE: begin
            // Any done with nobody owning the port is a violation
            err_d = isd_done | ixor_done;
            if (arb_gnt[0]) begin
               owner_d = OWN_SD;
               dir_d   = isd_dir;
               gbank_d = isd_dir ? send_ptr_q : fill_ptr_q;
            end else if (arb_gnt[1]) begin
               owner_d = OWN_XOR;
               gbank_d = proc_ptr_q;
            end
         end
         OWN_SD: begin
            err_d = ixor_done;
            if (isd_done) begin
               owner_d = OWN_IDLE;
               if (dir_q) begin
                  bank_d[gbank_q] = BK_EMPTY;
                  send_ptr_d      = ptr_inc(send_ptr_q, NBANKS);
               end else begin
                  bank_d[gbank_q] = BK_FULL;
                  fill_ptr_d      = ptr_inc(fill_ptr_q, NBANKS);
               end
            end
         end
         OWN_XOR: begin
            err_d = isd_done;
            if (ixor_done) begin
               owner_d         = OWN_IDLE;
               bank_d[gbank_q] = BK_DONE;
               proc_ptr_d      = ptr_inc(proc_ptr_q, NBANKS);
            end
         end
         default: owner_d = OWN_IDLE;
      endcase

      // Status registers reflect the post-update bank state
      for (int i = 0; i < NBANKS; i++)
         if (bank_d[i] == BK_EMPTY) free_d = free_d + 4'd1;
      idle_d = (free_d == 4'(NBANKS)) && (owner_d == OWN_IDLE);
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         for (int i = 0; i < MAX_BANKS; i++) bank_q[i] <= BK_EMPTY;
         fill_ptr_q <= '0;
         proc_ptr_q <= '0;
         send_ptr_q <= '0;
         owner_q    <= OWN_IDLE;
         dir_q      <= 1'b0;
         gbank_q    <= '0;
         free_q     <= 4'(NBANKS);
         idle_q     <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         bank_q     <= bank_d;
         fill_ptr_q <= fill_ptr_d;
         proc_ptr_q <= proc_ptr_d;
         send_ptr_q <= send_ptr_d;
         owner_q    <= owner_d;
         dir_q      <= dir_d;
         gbank_q    <= gbank_d;
         free_q     <= free_d;
         idle_q     <= idle_d;
         err_q      <= err_d;
      end
   end

   assign sd_own  = (owner_q == OWN_SD);
   assign xor_own = (owner_q == OWN_XOR);

   assign osd_gnt   = sd_own;
   assign oxor_gnt  = xor_own;
   assign osd_bank  = sd_own  ? gbank_q : 3'd0;
   assign oxor_bank = xor_own ? gbank_q : 3'd0;
   assign osel_ram  = (sd_own | xor_own) ? gbank_q : 3'd0;

   // SEND grants only read the RAM, so SD write enable is masked when dir = 1
   assign oaddr     = sd_own ? isd_addr  : (xor_own ? ixor_addr  : '0);
   assign owdata    = sd_own ? isd_wdata : (xor_own ? ixor_wdata : '0);
   assign owrite_en = (sd_own & isd_we & ~dir_q) | (xor_own & ixor_we);

   assign ofree = free_q;
   assign oidle = idle_q;
   assign oerr  = err_q;

endmodule

// File: tb/tb_ram_bank_sched.sv
module tb_ram_bank_sched;

   localparam int AW = 10;
   localparam int DW = 4;

   logic          iclk = 1'b0;
   logic          irst;
   logic          isd_req, isd_dir, isd_done, isd_we;
   logic [AW-1:0] isd_addr;
   logic [DW-1:0] isd_wdata;
   logic          osd_gnt;
   logic [2:0]    osd_bank;
   logic          ixor_req, ixor_done, ixor_we;
   logic [AW-1:0] ixor_addr;
   logic [DW-1:0] ixor_wdata;
   logic          oxor_gnt;
   logic [2:0]    oxor_bank;
   logic [2:0]    osel_ram;
   logic [AW-1:0] oaddr;
   logic [DW-1:0] owdata;
   logic          owrite_en;
   logic [DW-1:0] irdata;
   logic [3:0]    ofree;
   logic          oidle;
   logic          oerr;

   int n_chk = 0;
   int n_err = 0;

   ram_bank_sched #(.NBANKS(4), .AW(AW), .DW(DW)) dut (
      .iclk(iclk), .irst(irst),
      .isd_req(isd_req), .isd_dir(isd_dir), .isd_done(isd_done),
      .isd_addr(isd_addr), .isd_wdata(isd_wdata), .isd_we(isd_we),
      .osd_gnt(osd_gnt), .osd_bank(osd_bank),
      .ixor_req(ixor_req), .ixor_done(ixor_done),
      .ixor_addr(ixor_addr), .ixor_wdata(ixor_wdata), .ixor_we(ixor_we),
      .oxor_gnt(oxor_gnt), .oxor_bank(oxor_bank),
      .osel_ram(osel_ram), .oaddr(oaddr), .owdata(owdata), .owrite_en(owrite_en),
      .irdata(irdata), .ofree(ofree), .oidle(oidle), .oerr(oerr)
   );

   always #5 iclk = ~iclk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic do_reset();
      irst = 1'b1;
      tick();
      tick();
      irst = 1'b0;
      tick();
   endtask

   task automatic sd_grant(input logic dir, input int exp_bank);
      int k = 0;
      isd_req = 1'b1;
      isd_dir = dir;
      while (!osd_gnt && k < 10) begin tick(); k++; end
      chk("sd_gnt", osd_gnt, 1);
      chk("sd_bank", osd_bank, exp_bank);
   endtask

   task automatic sd_finish();
      isd_done = 1'b1;
      isd_req  = 1'b0;
      tick();
      isd_done = 1'b0;
      chk("sd_gnt_fall", osd_gnt, 0);
   endtask

   task automatic xor_grant(input int exp_bank);
      int k = 0;
      ixor_req = 1'b1;
      while (!oxor_gnt && k < 10) begin tick(); k++; end
      chk("xor_gnt", oxor_gnt, 1);
      chk("xor_bank", oxor_bank, exp_bank);
   endtask

   task automatic xor_finish();
      ixor_done = 1'b1;
      ixor_req  = 1'b0;
      tick();
      ixor_done = 1'b0;
      chk("xor_gnt_fall", oxor_gnt, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      irst = 1'b1;
      isd_req = 0; isd_dir = 0; isd_done = 0; isd_we = 0; isd_addr = '0; isd_wdata = '0;
      ixor_req = 0; ixor_done = 0; ixor_we = 0; ixor_addr = '0; ixor_wdata = '0;
      irdata = '0;

      // Reset state
      tick();
      chk("rst_sd_gnt", osd_gnt, 0);
      chk("rst_xor_gnt", oxor_gnt, 0);
      chk("rst_sel", osel_ram, 0);
      chk("rst_addr", oaddr, 0);
      chk("rst_we", owrite_en, 0);
      chk("rst_free", ofree, 4);
      chk("rst_idle", oidle, 1);
      chk("rst_err", oerr, 0);
      irst = 1'b0;
      tick();

      // 1: first FILL grant, write enable passes through
      isd_addr = 10'h155; isd_wdata = 4'hA; isd_we = 1'b1;
      isd_req = 1'b1; isd_dir = 1'b0;
      #1;
      chk("t1_we_idle", owrite_en, 0);
      tick();
      chk("t1_gnt_1cyc", osd_gnt, 1);
      chk("t1_bank", osd_bank, 0);
      chk("t1_we", owrite_en, 1);
      chk("t1_addr", oaddr, 10'h155);
      chk("t1_wdata", owdata, 4'hA);
      chk("t1_sel", osel_ram, 0);
      sd_finish();
      isd_we = 1'b0;
      chk("t1_free", ofree, 3);
      chk("t1_idle", oidle, 0);

      // 2: XOR b0, then SEND b0 (SD write enable masked)
      ixor_addr = 10'h123; ixor_wdata = 4'h5; ixor_we = 1'b1;
      xor_grant(0);
      chk("t2_xor_addr", oaddr, 10'h123);
      chk("t2_xor_wdata", owdata, 4'h5);
      chk("t2_xor_we", owrite_en, 1);
      xor_finish();
      ixor_we = 1'b0;
      chk("t2_free_after_xor", ofree, 3);
      isd_we = 1'b1;
      sd_grant(1'b1, 0);
      chk("t2_send_we", owrite_en, 0);
      sd_finish();
      isd_we = 1'b0;
      chk("t2_free_end", ofree, 4);
      chk("t2_idle_end", oidle, 1);

      // 3: both requesting continuously, grants alternate from SD
      do_reset();
      isd_req = 1'b1; isd_dir = 1'b0; ixor_req = 1'b1;
      for (int g = 0; g < 6; g++) begin
         int k = 0;
         while (!(osd_gnt || oxor_gnt) && k < 10) begin tick(); k++; end
         chk("t3_side_xor", oxor_gnt, g % 2);
         chk("t3_side_sd", osd_gnt, 1 - (g % 2));
         chk("t3_bank", oxor_gnt ? oxor_bank : osd_bank, g / 2);
         if (oxor_gnt) ixor_done = 1'b1;
         else          isd_done  = 1'b1;
         tick();
         ixor_done = 1'b0; isd_done = 1'b0;
      end
      isd_req = 1'b0; ixor_req = 1'b0;
      tick();
      chk("t3_free", ofree, 1);

      // 4: ring fills, fifth FILL stalls, then wraps to bank 0
      do_reset();
      for (int b = 0; b < 4; b++) begin
         sd_grant(1'b0, b);
         sd_finish();
      end
      chk("t4_free0", ofree, 0);
      isd_req = 1'b1; isd_dir = 1'b0;
      tick(); tick(); tick();
      chk("t4_stall", osd_gnt, 0);
      chk("t4_stall_free", ofree, 0);
      isd_req = 1'b0;
      xor_grant(0);
      xor_finish();
      sd_grant(1'b1, 0);
      sd_finish();
      chk("t4_free1", ofree, 1);
      sd_grant(1'b0, 0);

      // 5: XOR done while SD owns -> error, nothing moves
      ixor_done = 1'b1;
      tick();
      ixor_done = 1'b0;
      chk("t5_err", oerr, 1);
      chk("t5_gnt_held", osd_gnt, 1);
      chk("t5_bank_held", osd_bank, 0);
      chk("t5_free", ofree, 1);
      tick();
      chk("t5_err_pulse", oerr, 0);
      chk("t5_gnt_still", osd_gnt, 1);
      // both dones together: error, owner's done honoured
      isd_done = 1'b1; ixor_done = 1'b1; isd_req = 1'b0;
      tick();
      isd_done = 1'b0; ixor_done = 1'b0;
      chk("t5_both_err", oerr, 1);
      chk("t5_both_gnt", osd_gnt, 0);
      chk("t5_both_free", ofree, 0);

      // 6: reset in the middle of an XOR grant
      xor_grant(1);
      irst = 1'b1;
      #1;
      chk("t6_xor_gnt", oxor_gnt, 0);
      chk("t6_sd_gnt", osd_gnt, 0);
      chk("t6_free", ofree, 4);
      chk("t6_idle", oidle, 1);
      chk("t6_sel", osel_ram, 0);
      tick();
      irst = 1'b0;
      tick();
      chk("t6_xor_stall", oxor_gnt, 0);
      ixor_req = 1'b0;
      sd_grant(1'b0, 0);
      sd_finish();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
